key_stop_ctrl: RTL

Push-button front end that drives the `stop` input of the LED running-light state machine. It synchronises the raw, bouncing, active-low key and debounces it with a four-state filter FSM. It then emits a one-cycle press pulse and toggles a registered `stop` level on each confirmed press. A separate one-shot flags a long hold. Sits directly upstream of the LED sequencer, in the same `clk` domain.

---
 rtl/key_stop_ctrl_pkg.sv | 34 +++
 rtl/key_stop_ctrl_if.sv | 28 ++
 rtl/key_stop_ctrl_sync_2ff.sv | 29 ++
 rtl/key_stop_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/key_stop_ctrl_pkg.sv
// Shared definitions for the push-button front end: filter FSM encodings,
// board clock-rate constants and small helpers reused by the LED sequencer.
package key_stop_ctrl_pkg;

  // Debounce filter states.
  typedef enum logic [1:0] {
    KS_IDLE           = 2'd0,
    KS_PRESS_FILTER   = 2'd1,
    KS_PRESSED        = 2'd2,
    KS_RELEASE_FILTER = 2'd3
  } ks_state_e;

  // Board clock and default timing (50 MHz).
  localparam int unsigned CLK_FREQ_HZ         = 50_000_000;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;    // 20 ms
  localparam int unsigned DEF_LONG_CYCLES     = 100_000_000;  // 2 s

  // Convert a duration in milliseconds to clock cycles at CLK_FREQ_HZ.
  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return (CLK_FREQ_HZ / 1000) * ms;
  endfunction

  // Debounced level implied by a filter state: the key counts as held until
  // the release filter has fully confirmed the release.
  function automatic logic key_level_of(input ks_state_e st);
    return (st == KS_PRESSED) || (st == KS_RELEASE_FILTER);
  endfunction

  // Increment that sticks at lim instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] lim);
    return (v < lim) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/key_stop_ctrl_if.sv
// Key input and debounced outputs between the button front end and its user.
interface key_stop_ctrl_if;

  logic key_n;       // raw button, active-low, asynchronous
  logic key_level;   // debounced state, 1 = pressed
  logic key_pulse;   // one-cycle strobe per accepted press
  logic long_pulse;  // one-cycle strobe when a hold gets long
  logic stop;        // toggle level to the LED sequencer, 1 = frozen

  // Environment side: owns the button, consumes the results.
  modport master (
    output key_n,
    input  key_level,
    input  key_pulse,
    input  long_pulse,
    input  stop
  );

  // Controller side.
  modport slave (
    input  key_n,
    output key_level,
    output key_pulse,
    output long_pulse,
    output stop
  );

endinterface

// File: rtl/key_stop_ctrl_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous board input. The reset
// value is a parameter so idle-high and idle-low inputs both come out of
// reset in their inactive state.
module sync_2ff #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Shift the input through two flops; the first may go metastable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/key_stop_ctrl.sv
// Push-button front end for the LED running light. Synchronises and debounces
// the active-low key, strobes on each accepted press, toggles the registered
// stop level per press and flags a long hold with a separate one-shot.
module key_stop_ctrl
  import key_stop_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,  // >= 2
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES       // > DEBOUNCE_CYCLES
) (
  input  logic          clk,
  input  logic          rst_n,
  key_stop_ctrl_if.slave bus
);

  localparam logic [31:0] DebLast  = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] LongLast = 32'(LONG_CYCLES - 1);
  localparam logic [31:0] LongSat  = 32'(LONG_CYCLES);

  logic key_s;  // synchronised key, 0 = pressed

  ks_state_e   state_q, state_d;
  logic [31:0] cnt_q, cnt_d;    // stable-cycle counter for both filters
  logic [31:0] hold_q, hold_d;  // cycles spent in PRESSED for this press

  logic key_level_q, key_level_d;
  logic key_pulse_q, key_pulse_d;
  logic long_pulse_q, long_pulse_d;
  logic stop_q, stop_d;
  logic press_accept;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (bus.key_n),
    .q    (key_s)
  );

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= KS_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state and counter update for the debounce filter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    unique case (state_q)
      KS_IDLE: begin
        if (!key_s) begin
          state_d = KS_PRESS_FILTER;
          cnt_d   = '0;
        end
      end
      KS_PRESS_FILTER: begin
        if (key_s) begin
          // Bounce: start over.
          state_d = KS_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DebLast) begin
          state_d = KS_PRESSED;
          cnt_d   = '0;
          hold_d  = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      KS_PRESSED: begin
        hold_d = sat_inc(hold_q, LongSat);
        if (key_s) begin
          state_d = KS_RELEASE_FILTER;
          cnt_d   = '0;
        end
      end
      KS_RELEASE_FILTER: begin
        // hold stays frozen here so a release bounce does not restart it.
        if (!key_s) begin
          state_d = KS_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DebLast) begin
          state_d = KS_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = KS_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Next values of the registered outputs, decoded from the transition taken.
  always_comb begin
    press_accept = (state_q == KS_PRESS_FILTER) && !key_s && (cnt_q == DebLast);
    key_pulse_d  = press_accept;
    stop_d       = stop_q ^ press_accept;
    // hold saturates above LongLast, so this fires once per press.
    long_pulse_d = (state_q == KS_PRESSED) && (hold_q == LongLast);
    key_level_d  = key_level_of(state_d);
  end

  // Output registers; nothing reaches the outputs combinationally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_level_q  <= 1'b0;
      key_pulse_q  <= 1'b0;
      long_pulse_q <= 1'b0;
      stop_q       <= 1'b0;
    end else begin
      key_level_q  <= key_level_d;
      key_pulse_q  <= key_pulse_d;
      long_pulse_q <= long_pulse_d;
      stop_q       <= stop_d;
    end
  end

  assign bus.key_level  = key_level_q;
  assign bus.key_pulse  = key_pulse_q;
  assign bus.long_pulse = long_pulse_q;
  assign bus.stop       = stop_q;

  // The two strobes come from mutually exclusive states.
  assert property (@(posedge clk) disable iff (!rst_n) !(key_pulse_q && long_pulse_q));

endmodule
